pc_ctrl: RTL

Parametrised program-counter controller for the fetch stage of the pipelined MIPS core. Holds the fetch address and instruction-ROM chip enable, advances sequentially, redirects on branch/jump and on pipeline flush (exception entry/return), and honours the pipeline stall vector. A branch resolved while fetch is stalled is latched and applied on the first unstalled cycle, so it is never lost. Sits between the ctrl block (stall/flush/new_pc), the ID stage (branch resolution) and instruction ROM.

---
 rtl/pc_ctrl_pkg.sv | 17 +
 rtl/pc_ctrl_if.sv | 37 +++
 rtl/pc_ctrl_pend_latch.sv | 34 +++
 rtl/pc_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared fetch-stage constants and the pc_ctrl state encoding.
package pc_ctrl_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic NOSTOP      = 1'b0;
  localparam logic STOP        = 1'b1;
  localparam int   InstAddrBus = 32;

  typedef enum logic [1:0] {
    PC_ST_RESET = 2'd0,
    PC_ST_RUN   = 2'd1,
    PC_ST_PEND  = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-control bundle between ctrl/ID (master) and the PC controller (slave).
// misalign_o exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
`ifdef PC_ALIGN_CHECK_EN
  logic               misalign_o;

  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_target_i,
    input  pc, ce, misalign_o
  );
  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_target_i,
    output pc, ce, misalign_o
  );
`else
  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_target_i,
    input  pc, ce
  );
  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_target_i,
    output pc, ce
  );
`endif

endinterface

// File: rtl/pc_ctrl_pend_latch.sv
// Holds one branch target resolved while fetch was stalled; capture overwrites,
// release clears. Synchronous active-high reset discards any pending branch.
module pc_ctrl_pend_latch
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_capture,
  input  logic              i_release,
  input  logic [ADDR_W-1:0] i_target,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_target
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_target;

  always_ff @(posedge Clk) begin
    if (Rst == RstEnable) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid  <= 1'b1;
      r_target <= i_target;
    end else if (i_release) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_target = r_target;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC/ROM-enable controller: one-edge redirect on flush/branch/pending, stall[0] holds pc.
// Optional PC_ALIGN_CHECK_EN adds a registered misalign_o flag on the fetch address.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = InstAddrBus,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                STALL_W   = 6
) (
  input logic     Clk,
  input logic     Rst,
  pc_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  pc_state_t         r_state;
  pc_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_ce;
  logic              w_capture;
  logic              w_release;
  logic              w_pend_vld;
  logic [ADDR_W-1:0] w_pend_tgt;
  logic              w_unused_stall;

  // Only the fetch-stage bit matters here; later stages are someone else's concern.
  assign w_unused_stall = ^bus.stall[STALL_W-1:1];

  pc_ctrl_pend_latch #(.ADDR_W(ADDR_W)) u_pend (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_capture(w_capture),
    .i_release(w_release),
    .i_target (bus.branch_target_i),
    .o_valid  (w_pend_vld),
    .o_target (w_pend_tgt)
  );

  always_ff @(posedge Clk) begin
    if (Rst == RstEnable) begin
      r_state <= PC_ST_RESET;
      r_pc    <= RESET_VEC;
      r_ce    <= ChipDisable;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ce    <= (w_state_nxt == PC_ST_RESET) ? ChipDisable : ChipEnable;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      PC_ST_RESET: begin
        // First fetch after reset is RESET_VEC itself, so pc is not advanced here.
        w_state_nxt = PC_ST_RUN;
      end
      default: begin
        if (bus.flush) begin
          w_pc_nxt    = bus.new_pc;
          w_release   = 1'b1;
          w_state_nxt = PC_ST_RUN;
        end else if (bus.stall[0] == STOP) begin
          if (bus.branch_flag_i) begin
            w_capture   = 1'b1;
            w_state_nxt = PC_ST_PEND;
          end
        end else if (bus.branch_flag_i) begin
          w_pc_nxt    = bus.branch_target_i;
          w_release   = 1'b1;
          w_state_nxt = PC_ST_RUN;
        end else if (w_pend_vld) begin
          w_pc_nxt    = w_pend_tgt;
          w_release   = 1'b1;
          w_state_nxt = PC_ST_RUN;
        end else begin
          w_pc_nxt = r_pc + STEP_W;
        end
      end
    endcase
  end

  assign bus.pc = r_pc;
  assign bus.ce = r_ce;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  // Flag tracks the value pc takes on the same edge; unaligned pc still loads.
  always_ff @(posedge Clk) begin
    if (Rst == RstEnable) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= ((w_pc_nxt % STEP_W) != '0);
    end
  end

  assign bus.misalign_o = r_misalign;
`endif

endmodule
